// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus Mini-SRC datapath.
// Runs fetch T0-T2, then decodes IR[31:27] and sequences ld/ldi/st/add/nop/halt.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for Start (with Stop low); all strobes low
//   T0    | fetch: PCout, MARin, IncPC
//   T1    | fetch: Read, MDRin
//   T2    | fetch: MDRout, IRin (IR loads on the edge leaving T2)
//   T3    | decode live IR; first execute step (nop/halt/illegal end here)
//   T4    | execute step 2
//   T5    | execute step 3 (ldi/add end here)
//   T6    | execute step 4
//   T7    | execute step 5 (ld/st end here)
//   HALT  | stopped by halt or an illegal opcode; Run low
module control_sequencer #(
    parameter logic [4:0] OP_LD   = 5'b00000,
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_ST   = 5'b00010,
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        Start,
    input  logic        Stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Yin,
    output logic        ADD,
    output logic        BAout,
    output logic        Rin,
    output logic        Rout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Run,
    output logic        Illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    state_t     boundary_state;
    logic       stop_pending;
    logic       illegal_q;
    logic       in_t_state;
    logic [4:0] opcode;
    logic       op_ld;
    logic       op_ldi;
    logic       op_st;
    logic       op_add;
    logic       op_nop;
    logic       op_halt;
    logic       op_legal;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign op_ld    = (opcode == OP_LD);
    assign op_ldi   = (opcode == OP_LDI);
    assign op_st    = (opcode == OP_ST);
    assign op_add   = (opcode == OP_ADD);
    assign op_nop   = (opcode == OP_NOP);
    assign op_halt  = (opcode == OP_HALT);
    assign op_legal = op_ld | op_ldi | op_st | op_add | op_nop | op_halt;

    assign in_t_state = (cur_state >= S_T0) && (cur_state <= S_T7);

    // A stop request seen anywhere in the instruction takes effect at its last step.
    assign boundary_state = (stop_pending || Stop) ? S_IDLE : S_T0;

    assign state   = cur_state;
    assign Illegal = illegal_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stop_pending <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (nxt_state == S_IDLE) begin
                stop_pending <= 1'b0;
            end else if (in_t_state && Stop) begin
                stop_pending <= 1'b1;
            end
            if (cur_state == S_T3 && !op_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (Start && !Stop) nxt_state = S_T0;
            end
            S_T0: nxt_state = S_T1;
            S_T1: nxt_state = S_T2;
            S_T2: nxt_state = S_T3;
            S_T3: begin
                if (op_ld || op_st || op_ldi || op_add) nxt_state = S_T4;
                else if (op_nop)                       nxt_state = boundary_state;
                else                                   nxt_state = S_HALT;
            end
            S_T4: nxt_state = S_T5;
            S_T5: begin
                if (op_ld || op_st) nxt_state = S_T6;
                else                nxt_state = boundary_state;
            end
            S_T6: nxt_state = S_T7;
            S_T7: nxt_state = boundary_state;
            S_HALT: begin
                if (Start && !Stop && !illegal_q) nxt_state = S_T0;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Yin      = 1'b0;
        ADD      = 1'b0;
        BAout    = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Cout     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Run      = in_t_state;
        case (cur_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (op_ld || op_st || op_ldi) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (op_add) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                if (op_ld || op_st || op_ldi) begin
                    Cout = 1'b1;
                    ADD  = 1'b1;
                    Zin  = 1'b1;
                end else if (op_add) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                    ADD  = 1'b1;
                    Zin  = 1'b1;
                end
            end
            S_T5: begin
                if (op_ld || op_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (op_ldi || op_add) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            S_T6: begin
                if (op_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (op_st) begin
                    // Store data goes bus -> MDR, so Read stays low here.
                    Gra   = 1'b1;
                    BAout = 1'b1;
                    MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (op_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (op_st) begin
                    MDRout = 1'b1;
                    Write  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: per-step strobe tables for each
// instruction, stop/halt/illegal handling, and async clear mid-instruction.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic        Start;
    logic        Stop;
    logic [31:0] IR;
    logic PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
    logic Zin, Zlowout, Zhighout, Yin, ADD, BAout, Rin, Rout, Cout;
    logic Gra, Grb, Grc, Run, Illegal;
    logic [3:0] state;
    logic [20:0] strobes;

    localparam logic [20:0] M_PCOUT    = 21'd1 << 20;
    localparam logic [20:0] M_MARIN    = 21'd1 << 19;
    localparam logic [20:0] M_INCPC    = 21'd1 << 18;
    localparam logic [20:0] M_READ     = 21'd1 << 16;
    localparam logic [20:0] M_WRITE    = 21'd1 << 15;
    localparam logic [20:0] M_MDRIN    = 21'd1 << 14;
    localparam logic [20:0] M_MDROUT   = 21'd1 << 13;
    localparam logic [20:0] M_IRIN     = 21'd1 << 12;
    localparam logic [20:0] M_ZIN      = 21'd1 << 11;
    localparam logic [20:0] M_ZLOWOUT  = 21'd1 << 10;
    localparam logic [20:0] M_YIN      = 21'd1 << 8;
    localparam logic [20:0] M_ADD      = 21'd1 << 7;
    localparam logic [20:0] M_BAOUT    = 21'd1 << 6;
    localparam logic [20:0] M_RIN      = 21'd1 << 5;
    localparam logic [20:0] M_ROUT     = 21'd1 << 4;
    localparam logic [20:0] M_COUT     = 21'd1 << 3;
    localparam logic [20:0] M_GRA      = 21'd1 << 2;
    localparam logic [20:0] M_GRB      = 21'd1 << 1;
    localparam logic [20:0] M_GRC      = 21'd1 << 0;

    int checks;
    int failures;
    int write_cnt;
    logic [20:0] exp_tab [8];

    control_sequencer dut (
        .clk(clk), .clr(clr), .Start(Start), .Stop(Stop), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Yin(Yin), .ADD(ADD),
        .BAout(BAout), .Rin(Rin), .Rout(Rout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Run(Run), .Illegal(Illegal), .state(state)
    );

    assign strobes = {PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
                      Zin, Zlowout, Zhighout, Yin, ADD, BAout, Rin, Rout, Cout,
                      Gra, Grb, Grc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch();
        for (int i = 0; i < 8; i++) exp_tab[i] = '0;
        exp_tab[0] = M_PCOUT | M_MARIN | M_INCPC;
        exp_tab[1] = M_READ | M_MDRIN;
        exp_tab[2] = M_MDROUT | M_IRIN;
    endtask

    // Entered with the machine already sampled in T0; returns one edge past the last step.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int n, input int stop_at);
        IR = ir;
        write_cnt = 0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_state_t%0d", tag, i), 32'(state), 32'(i + 1));
            check($sformatf("%s_strobes_t%0d", tag, i), 32'(strobes), 32'(exp_tab[i]));
            check($sformatf("%s_run_t%0d", tag, i), 32'(Run), 32'd1);
            if (Write) write_cnt++;
            Stop = (i == stop_at);
            tick();
        end
        Stop = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clr = 1'b1;
        Start = 1'b0;
        Stop = 1'b0;
        IR = '0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'(strobes), 32'd0);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        clr = 1'b0;
        tick();
        check("idle_hold", 32'(state), 32'd0);

        // st $90,R4
        Start = 1'b1;
        tick();
        Start = 1'b0;
        set_fetch();
        exp_tab[3] = M_GRB | M_BAOUT | M_YIN;
        exp_tab[4] = M_COUT | M_ADD | M_ZIN;
        exp_tab[5] = M_ZLOWOUT | M_MARIN;
        exp_tab[6] = M_GRA | M_BAOUT | M_MDRIN;
        exp_tab[7] = M_MDROUT | M_WRITE;
        run_instr("st", 32'h1200_0090, 8, -1);
        check("st_write_cycles", 32'(write_cnt), 32'd1);
        check("st_next_t0", 32'(state), 32'd1);

        // ld R1,$85
        set_fetch();
        exp_tab[3] = M_GRB | M_BAOUT | M_YIN;
        exp_tab[4] = M_COUT | M_ADD | M_ZIN;
        exp_tab[5] = M_ZLOWOUT | M_MARIN;
        exp_tab[6] = M_READ | M_MDRIN;
        exp_tab[7] = M_MDROUT | M_GRA | M_RIN;
        run_instr("ld", 32'h0080_0085, 8, -1);
        check("ld_next_t0", 32'(state), 32'd1);

        // add R3,R1,R2
        set_fetch();
        exp_tab[3] = M_GRB | M_ROUT | M_YIN;
        exp_tab[4] = M_GRC | M_ROUT | M_ADD | M_ZIN;
        exp_tab[5] = M_ZLOWOUT | M_GRA | M_RIN;
        run_instr("add", 32'h1989_0000, 6, -1);
        check("add_next_t0", 32'(state), 32'd1);

        // ldi with Stop pulsed in T2: completes, then IDLE
        set_fetch();
        exp_tab[3] = M_GRB | M_BAOUT | M_YIN;
        exp_tab[4] = M_COUT | M_ADD | M_ZIN;
        exp_tab[5] = M_ZLOWOUT | M_GRA | M_RIN;
        run_instr("ldi", 32'h0880_0007, 6, 2);
        check("ldi_stop_idle", 32'(state), 32'd0);
        check("ldi_stop_run", 32'(Run), 32'd0);
        Start = 1'b1;
        Stop = 1'b1;
        tick();
        check("start_stop_idle", 32'(state), 32'd0);
        Stop = 1'b0;
        tick();
        check("start_resume_t0", 32'(state), 32'd1);
        Start = 1'b0;

        // nop: 4-cycle instruction
        set_fetch();
        run_instr("nop", 32'hD000_0000, 4, -1);
        check("nop_next_t0", 32'(state), 32'd1);

        // halt
        set_fetch();
        run_instr("halt", 32'hD800_0000, 4, -1);
        check("halt_state", 32'(state), 32'd15);
        check("halt_run", 32'(Run), 32'd0);
        check("halt_strobes", 32'(strobes), 32'd0);
        check("halt_illegal", 32'(Illegal), 32'd0);
        tick();
        check("halt_hold", 32'(state), 32'd15);
        Start = 1'b1;
        tick();
        check("halt_resume_t0", 32'(state), 32'd1);
        Start = 1'b0;

        // undefined opcode 11111
        set_fetch();
        run_instr("ill", 32'hF800_0000, 4, -1);
        check("ill_state", 32'(state), 32'd15);
        check("ill_flag", 32'(Illegal), 32'd1);
        check("ill_run", 32'(Run), 32'd0);
        Start = 1'b1;
        tick();
        tick();
        check("ill_start_ignored", 32'(state), 32'd15);
        check("ill_sticky", 32'(Illegal), 32'd1);
        Start = 1'b0;
        clr = 1'b1;
        #1;
        check("ill_clr_state", 32'(state), 32'd0);
        check("ill_clr_flag", 32'(Illegal), 32'd0);
        clr = 1'b0;

        // async clear in T5 of a ld
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        IR = 32'h0080_0085;
        for (int i = 0; i < 5; i++) tick();
        check("ld_mid_state", 32'(state), 32'd6);
        check("ld_mid_strobes", 32'(strobes), 32'(M_ZLOWOUT | M_MARIN));
        #2;
        clr = 1'b1;
        #1;
        check("clr_mid_state", 32'(state), 32'd0);
        check("clr_mid_strobes", 32'(strobes), 32'd0);
        check("clr_mid_run", 32'(Run), 32'd0);
        check("clr_mid_illegal", 32'(Illegal), 32'd0);
        #2;
        clr = 1'b0;
        tick();
        check("clr_mid_stays_idle", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus Mini-SRC datapath.
- Generates every datapath control strobe that benches currently drive by hand: PCout, MARin, Read, MDRin, Gra, BAout, Write, and the rest.
- Runs the fetch sequence T0-T2, then decodes IR[31:27] and sequences the execute steps for ld, ldi, st, add, nop and halt.
- Sits beside Datapath; its outputs connect port-for-port to the Datapath control inputs, and its IR input comes from Datapath IRdataout.

Parameters:
OP_LD, 5'b00000, ld opcode
OP_LDI, 5'b00001, ldi opcode
OP_ST, 5'b00010, st opcode
OP_ADD, 5'b00011, add opcode
OP_NOP, 5'b11010, nop opcode
OP_HALT, 5'b11011, halt opcode

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  asynchronous, active-high reset
Start  in  1  level; begins/resumes fetching from IDLE or HALT
Stop  in  1  level; request to stop at next instruction boundary
IR  in  32  instruction register contents (Datapath IRdataout)
PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin  out  1 each  datapath strobes
Zin, Zlowout, Zhighout, Yin, ADD, BAout, Rin, Rout, Cout  out  1 each  datapath strobes
Gra, Grb, Grc  out  1 each  register-field select strobes
Run  out  1  high in T0..T7
Illegal  out  1  sticky; undefined opcode seen
state  out  4  debug: current state encoding

Behaviour:
- States and encoding: IDLE=0, T0..T7=1..8, HALT=15.
- Moore machine. Strobes decode from the state register plus IR[31:27]. Each strobe is high for exactly the full cycle of its step and low at every other time.
- clr (async) forces IDLE, clears Illegal and the internal stop_pending flag, and drives all strobes and Run to 0. The same applies when clr arrives mid-instruction, with no partial completion.
- IDLE: if Start=1 and Stop=0, go to T0; otherwise stay. Start and Stop together in IDLE leaves the machine in IDLE.
- Fetch (all opcodes):
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- IR is loaded at the T2->T3 edge. The decode is therefore performed in T3 from the live IR input, and IR must be stable from T3 until the instruction ends.
- Execute steps (unlisted strobes are 0):
  - ld: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin; 8 cycles total.
  - st: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Gra BAout MDRin (Read=0, MDR loads from bus); T7 MDRout Write; 8 cycles total.
  - ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin; 6 cycles total.
  - add: T3 Grb Rout Yin; T4 Grc Rout ADD Zin; T5 Zlowout Gra Rin; 6 cycles total.
  - nop: T3 no strobes; 4 cycles total.
  - halt: T3 no strobes, then go to HALT.
- Undefined opcode: T3 asserts no strobes, sets Illegal, then goes to HALT.
- Instruction boundary is the last step (T7 for ld/st, T5 for ldi/add, T3 for nop).
  - Next state is IDLE if stop_pending or Stop=1; otherwise T0.
  - stop_pending is set by Stop=1 in any T-state and cleared on entry to IDLE.
- HALT: Run=0 and no strobes. Start=1 (Stop=0) goes to T0, provided Illegal=0. When Illegal=1, HALT is left only via clr.
- Zhighout is always 0. PCin is always 0 (reserved for branch support).
- state output equals the state register.
- No strobe may glitch high between steps.

Test Plan:
- Reset: clr=1 mid-T5 of a ld -> state=0 immediately (async), all strobes 0, Run=0, Illegal=0.
- st $90,R4 (IR=0x12000090), pulse Start:
  - T0..T7 strobes exactly as listed.
  - Write high for exactly one cycle, at cycle 8.
  - With Datapath, R4=0x67: RAM[0x90]=0x67.
  - Then back to T0.
- ld R1,$85 (IR=0x00800085):
  - T6 Read+MDRin; T7 MDRout+Gra+Rin.
  - With Datapath: R1=RAM[0x85].
  - 8 cycles from T0 to next T0.
- add R3,R1,R2 (IR=0x19890000):
  - T4 Grc+Rout+ADD+Zin; T5 Gra+Rin.
  - With R1=5, R2=6: R3=11.
  - 6-cycle period.
- Stop=1 pulsed during T2 of an ldi (IR=0x08800007) -> instruction completes through T5, then IDLE. Start with Stop=1 stays in IDLE; Start alone goes to T0.
- halt (IR=0xD8000000) -> HALT after T3, Run=0, Start resumes at T0. Opcode 11111 (IR=0xF8000000) -> Illegal=1, HALT, Start ignored until clr.
